// File: rtl/reg_bank_decoder.sv
// Shared access decoder for a contiguous window of configuration registers.
// Applies programmable wait states and returns a single-cycle ack/err response.
module reg_bank_decoder #(
  parameter int                  W_WIDTH     = 8,
  parameter int                  NUM_REGS    = 4,
  parameter int                  BASE_ADDR   = 0,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel_en,
  input  logic                          wr_rd_s,
  input  logic [W_WIDTH-1:0]            addr,
  input  logic [W_WIDTH-1:0]            wr_data_in,
  input  logic [NUM_REGS*W_WIDTH-1:0]   reg_data2port_in,
  output logic [NUM_REGS-1:0]           wr_en,
  output logic [W_WIDTH-1:0]            wr_data,
  output logic [W_WIDTH-1:0]            rd_data,
  output logic                          ack,
  output logic                          err,
  output logic                          busy
);

  localparam int               IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [W_WIDTH:0] BASE_EXT = (W_WIDTH+1)'(BASE_ADDR);
  localparam logic [W_WIDTH:0] NUM_EXT  = (W_WIDTH+1)'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 wr_q;
  logic [W_WIDTH-1:0]   addr_q;
  logic [W_WIDTH-1:0]   data_q;

  logic [NUM_REGS-1:0]  wr_en_q;
  logic [W_WIDTH-1:0]   wr_data_q;
  logic [W_WIDTH-1:0]   rd_data_q;
  logic                 ack_q;
  logic                 err_q;
  logic                 busy_q;

  logic                 src_wr;
  logic [W_WIDTH-1:0]   src_addr;
  logic [W_WIDTH-1:0]   src_data;
  logic [W_WIDTH:0]     off;
  logic                 hit;
  logic [IDX_W-1:0]     idx;
  logic [NUM_REGS-1:0]  onehot;
  logic                 ro_hit;
  logic [W_WIDTH-1:0]   rd_sel;
  logic                 go_resp;
  logic [NUM_REGS-1:0]  wr_en_d;
  logic [W_WIDTH-1:0]   wr_data_d;
  logic [W_WIDTH-1:0]   rd_data_d;
  logic                 err_d;

  // With no wait states the response is decoded straight from the live inputs
  // on the sampling edge; otherwise from the copy captured in IDLE.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    src_wr   = (state_q == S_IDLE) ? wr_rd_s    : wr_q;
    src_addr = (state_q == S_IDLE) ? addr       : addr_q;
    src_data = (state_q == S_IDLE) ? wr_data_in : data_q;

    off    = {1'b0, src_addr} - BASE_EXT;
    hit    = ({1'b0, src_addr} >= BASE_EXT) && (off < NUM_EXT);
    idx    = off[IDX_W-1:0];
    onehot = '0;
    ro_hit = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = hit && (idx == IDX_W'(i));
      ro_hit    = ro_hit | (onehot[i] & RO_MASK[i]);
      rd_sel    = rd_sel | ({W_WIDTH{onehot[i]}} & reg_data2port_in[i*W_WIDTH +: W_WIDTH]);
    end

    wr_en_d   = (hit && src_wr && !ro_hit) ? onehot : '0;
    wr_data_d = (hit && src_wr && !ro_hit) ? src_data : '0;
    rd_data_d = (hit && !src_wr) ? rd_sel : '0;
    err_d     = !hit || (src_wr && ro_hit);

    go_resp = sel_en && (((state_q == S_IDLE) && (WAIT_CYCLES == 0)) ||
                         ((state_q == S_WAIT) && (cnt_q == 4'd1)));
  end

  // NOTE: reset is asynchronous so a pulse on rst_n clears the outputs and drops any in-flight access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      wr_en_q   <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;

      if (go_resp) begin
        state_q   <= S_RESP;
        cnt_q     <= '0;
        busy_q    <= 1'b1;
        ack_q     <= 1'b1;
        err_q     <= err_d;
        wr_en_q   <= wr_en_d;
        wr_data_q <= wr_data_d;
        rd_data_q <= rd_data_d;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (sel_en) begin
              wr_q    <= wr_rd_s;
              addr_q  <= addr;
              data_q  <= wr_data_in;
              cnt_q   <= 4'(WAIT_CYCLES);
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (!sel_en) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          S_RESP: begin
            state_q <= sel_en ? S_HOLD : S_IDLE;
            busy_q  <= sel_en;
          end
          S_HOLD: begin
            if (!sel_en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign rd_data = rd_data_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_bank_decoder.sv
// Directed bench for reg_bank_decoder: one instance with no wait states and a
// read-only register 0, one with three wait states and every register writable.
module tb_reg_bank_decoder;

  logic       clk;
  logic       rst_n;
  logic       sel_en     [2];
  logic       wr_rd_s    [2];
  logic [7:0] addr       [2];
  logic [7:0] wr_data_in [2];
  logic [31:0] regs      [2];
  logic [3:0] wr_en      [2];
  logic [7:0] wr_data    [2];
  logic [7:0] rd_data    [2];
  logic       ack        [2];
  logic       err        [2];
  logic       busy       [2];

  int n_tests = 0;
  int n_fail  = 0;

  reg_bank_decoder #(
    .W_WIDTH(8), .NUM_REGS(4), .BASE_ADDR(8'h10), .WAIT_CYCLES(0), .RO_MASK(4'b0001)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel_en[0]), .wr_rd_s(wr_rd_s[0]),
    .addr(addr[0]), .wr_data_in(wr_data_in[0]), .reg_data2port_in(regs[0]),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]),
    .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  reg_bank_decoder #(
    .W_WIDTH(8), .NUM_REGS(4), .BASE_ADDR(8'h10), .WAIT_CYCLES(3), .RO_MASK(4'b0000)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sel_en(sel_en[1]), .wr_rd_s(wr_rd_s[1]),
    .addr(addr[1]), .wr_data_in(wr_data_in[1]), .reg_data2port_in(regs[1]),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]),
    .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] exp_wr_en;
    logic [7:0] exp_wr_data;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_idle(input string name, input int d);
    check({name, " ack"},     32'(ack[d]),     32'd0);
    check({name, " err"},     32'(err[d]),     32'd0);
    check({name, " wr_en"},   32'(wr_en[d]),   32'd0);
    check({name, " wr_data"}, 32'(wr_data[d]), 32'd0);
    check({name, " rd_data"}, 32'(rd_data[d]), 32'd0);
    check({name, " busy"},    32'(busy[d]),    32'd0);
  endtask

  // One full access with sel_en held past the response to exercise HOLD.
  task automatic run_vec(input vec_t v, input string tag);
    int d;
    int lat;
    int extra_acks;
    int exp_lat;
    d       = v.dut;
    exp_lat = (d == 0) ? 1 : 4;
    lat     = 0;
    @(negedge clk);
    sel_en[d]     = 1'b1;
    wr_rd_s[d]    = v.wr;
    addr[d]       = v.addr;
    wr_data_in[d] = v.data;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        wr_rd_s[d]    = ~v.wr;
        addr[d]       = ~v.addr;
        wr_data_in[d] = ~v.data;
      end
      if (ack[d]) begin
        lat = c;
        check({tag, " err"},     32'(err[d]),     32'(v.exp_err));
        check({tag, " wr_en"},   32'(wr_en[d]),   32'(v.exp_wr_en));
        check({tag, " wr_data"}, 32'(wr_data[d]), 32'(v.exp_wr_data));
        check({tag, " rd_data"}, 32'(rd_data[d]), 32'(v.exp_rd));
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, " post wr_en"},   32'(wr_en[d]),   32'd0);
    check({tag, " post rd_data"}, 32'(rd_data[d]), 32'd0);
    check({tag, " post busy"},    32'(busy[d]),    32'd1);
    extra_acks = int'(ack[d]);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      extra_acks += int'(ack[d]);
    end
    check({tag, " repeat ack"}, 32'(extra_acks), 32'd0);
    @(negedge clk);
    sel_en[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle busy"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    int acks;
    int strobes;

    // reg0..reg3 of each instance live at bits [i*8 +: 8]
    regs[0] = 32'h44332211;
    regs[1] = 32'h3C2B1A09;
    for (int d = 0; d < 2; d++) begin
      sel_en[d] = 1'b0; wr_rd_s[d] = 1'b0; addr[d] = '0; wr_data_in[d] = '0;
    end

    vecs[0]  = '{0, 1'b1, 8'h12, 8'hA5, 4'b0100, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1, 1'b0, 8'h13, 8'h00, 4'b0000, 8'h00, 8'h3C, 1'b0};
    vecs[2]  = '{0, 1'b0, 8'h11, 8'h00, 4'b0000, 8'h00, 8'h22, 1'b0};
    vecs[3]  = '{0, 1'b0, 8'h0F, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{0, 1'b1, 8'h14, 8'h5A, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{1, 1'b0, 8'h14, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1, 1'b1, 8'h0F, 8'h66, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{0, 1'b1, 8'h10, 8'hFF, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1, 1'b1, 8'h10, 8'hFF, 4'b0001, 8'hFF, 8'h00, 1'b0};
    vecs[9]  = '{0, 1'b1, 8'h13, 8'h77, 4'b1000, 8'h77, 8'h00, 1'b0};
    vecs[10] = '{1, 1'b0, 8'h10, 8'h00, 4'b0000, 8'h00, 8'h09, 1'b0};
    vecs[11] = '{0, 1'b0, 8'hFF, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset dut0", 0);
    check_idle("reset dut3", 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort: sel_en dropped in the second wait cycle.
    @(negedge clk);
    sel_en[1] = 1'b1; wr_rd_s[1] = 1'b1; addr[1] = 8'h11; wr_data_in[1] = 8'h5A;
    @(posedge clk); #1;
    check("abort busy in wait", 32'(busy[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    sel_en[1] = 1'b0;
    @(posedge clk); #1;
    check("abort busy cleared", 32'(busy[1]), 32'd0);
    acks = 0; strobes = 0;
    for (int c = 0; c < 6; c++) begin
      acks    += int'(ack[1]);
      strobes += int'(wr_en[1] != 4'b0000);
      @(posedge clk); #1;
    end
    check("abort acks", 32'(acks), 32'd0);
    check("abort wr_en", 32'(strobes), 32'd0);

    // Reset asserted mid-wait on the wait-state instance.
    @(negedge clk);
    sel_en[1] = 1'b1; wr_rd_s[1] = 1'b0; addr[1] = 8'h13;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_idle("rst in wait", 1);
    sel_en[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      acks += int'(ack[1]);
    end
    check("rst in wait later ack", 32'(acks), 32'd0);
    run_vec(vecs[1], "after rst wait");

    // Reset asserted during the response cycle of the no-wait instance.
    @(negedge clk);
    sel_en[0] = 1'b1; wr_rd_s[0] = 1'b1; addr[0] = 8'h11; wr_data_in[0] = 8'hC3;
    @(posedge clk); #1;
    check("resp ack before rst", 32'(ack[0]), 32'd1);
    check("resp wr_en before rst", 32'(wr_en[0]), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst in resp", 0);
    sel_en[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      acks += int'(ack[0]);
    end
    check("rst in resp later ack", 32'(acks), 32'd0);
    run_vec(vecs[0], "after rst resp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
